store_trace_fifo: RTL and testbench

- Downstream consumer of the CPU memory stage.
- Captures every store presented on memwriteM/aluoutM/writedataM into a FWFT FIFO, each tagged with a sequence number.
- Drains entries over a valid/ready stream to a checker, UART bridge or debug host.
- Keeps sticky overflow/drop statistics so lost stores are never silent.

---
 rtl/store_trace_fifo_pkg.sv | 19 +
 rtl/store_trace_fifo_if.sv | 35 +++
 rtl/store_trace_fifo_fwft.sv | 55 +++++
 rtl/store_trace_fifo.sv | 99 +++++++++
 tb/tb_store_trace_fifo.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/store_trace_fifo_pkg.sv
// Shared types and constants for the store trace FIFO.
// The top module store_trace_fifo also has an optional address-window filter, selected by the STORE_TRACE_FILTER_EN macro.
package store_trace_pkg;

  localparam int STORE_SEQ_W = 16;
  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  typedef struct packed {
    logic [31:0]            addr;
    logic [31:0]            data;
    logic [STORE_SEQ_W-1:0] seq;
    logic                   misaligned;
  } store_entry_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |(addr[1:0] & WORD_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/store_trace_fifo_if.sv
// Store capture and drain bus between the memory stage, the trace FIFO and its consumer.
// slave is the FIFO's own view of the bus; master is the view of whatever drives it.
interface store_trace_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int SEQ_W  = 16,
  parameter int DROP_W = 8
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              memwriteM;
  logic [31:0]       aluoutM;
  logic [31:0]       writedataM;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;
  logic [SEQ_W-1:0]  out_seq;
  logic              out_misaligned;
  logic              clr_stats;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport slave (
    input  memwriteM, aluoutM, writedataM, out_ready, clr_stats,
    output out_valid, out_addr, out_data, out_seq, out_misaligned,
           level, overflow, drop_cnt
  );

  modport master (
    output memwriteM, aluoutM, writedataM, out_ready, clr_stats,
    input  out_valid, out_addr, out_data, out_seq, out_misaligned,
           level, overflow, drop_cnt
  );
endinterface

// File: rtl/store_trace_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// The head entry is read combinationally from storage.
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_reg;
  logic [AW-1:0]    rptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LW'(DEPTH));
  // A push is legal while full only if the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rptr_reg];
  assign level   = level_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + 1'b1;
      if (pop_ok)  rptr_reg <= rptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end
endmodule

// File: rtl/store_trace_fifo.sv
// Captures memory-stage stores with sequence numbers into a FWFT FIFO and keeps drop statistics.
// Define STORE_TRACE_FILTER_EN to capture only stores whose address lies in the FILTER_BASE/FILTER_SIZE window.
module store_trace_fifo
  import store_trace_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter int          SEQ_W       = 16,
  parameter int          DROP_W      = 8,
  parameter logic [31:0] FILTER_BASE = 32'h0000_0000,
  parameter logic [31:0] FILTER_SIZE = 32'h0000_0100
) (
  input logic clk,
  input logic reset,
  store_trace_fifo_if.slave bus
);
  localparam int EW = 32 + 32 + SEQ_W + 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic              capture;
  logic              push;
  logic              pop;
  logic              drop;
  logic              full;
  logic              empty;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     head;
  logic [EW-1:0]     head_masked;
  logic [LW-1:0]     level;
  logic [SEQ_W-1:0]  seq_reg;
  logic              overflow_reg;
  logic [DROP_W-1:0] drop_cnt_reg;

`ifdef STORE_TRACE_FILTER_EN
  logic [32:0] addr_ext;
  logic [32:0] win_lo;
  logic [32:0] win_hi;
  // Bounds are widened by one bit so that the top of the window cannot wrap.
  assign addr_ext = {1'b0, bus.aluoutM};
  assign win_lo   = {1'b0, FILTER_BASE};
  assign win_hi   = {1'b0, FILTER_BASE} + {1'b0, FILTER_SIZE};
  assign capture  = bus.memwriteM && (addr_ext >= win_lo) && (addr_ext < win_hi);
`else
  logic unused_filter;
  assign unused_filter = ^{FILTER_BASE, FILTER_SIZE};
  assign capture       = bus.memwriteM;
`endif

  assign pop      = !empty && bus.out_ready;
  assign push     = capture && (!full || pop);
  assign drop     = capture && full && !pop;
  assign wr_entry = {bus.aluoutM, bus.writedataM, seq_reg, is_misaligned(bus.aluoutM)};

  sync_fifo_fwft #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // Stale storage is hidden so that an empty FIFO presents all-zero head fields.
  for (genvar gi = 0; gi < EW; gi++) begin : g_head_mask
    assign head_masked[gi] = head[gi] & !empty;
  end

  assign {bus.out_addr, bus.out_data, bus.out_seq, bus.out_misaligned} = head_masked;
  assign bus.out_valid = !empty;
  assign bus.level     = level;
  assign bus.overflow  = overflow_reg;
  assign bus.drop_cnt  = drop_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_reg      <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      // Dropped stores still consume a number so the consumer sees the gap.
      if (capture) seq_reg <= seq_reg + 1'b1;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (bus.clr_stats)
          drop_cnt_reg <= DROP_W'(1);
        else if (drop_cnt_reg != '1)
          drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end else if (bus.clr_stats) begin
        overflow_reg <= 1'b0;
        drop_cnt_reg <= '0;
      end
    end
  end
endmodule

// File: tb/tb_store_trace_fifo.sv
// Directed-vector bench for store_trace_fifo (DEPTH=8, SEQ_W=16, DROP_W=8).
// Also covers the address filter when STORE_TRACE_FILTER_EN is defined.
module tb_store_trace_fifo;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  store_trace_fifo_if #(.DEPTH(8), .SEQ_W(16), .DROP_W(8)) bus ();

  store_trace_fifo #(
    .DEPTH       (8),
    .SEQ_W       (16),
    .DROP_W      (8),
    .FILTER_BASE (32'h0000_0000),
    .FILTER_SIZE (32'h0000_0100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      $display("[TB] check %-14s observed=%0h expected=%0h", tag, obs, exp);
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.memwriteM  = 1'b1;
    bus.aluoutM    = addr;
    bus.writedataM = data;
    tick();
    bus.memwriteM  = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.memwriteM  = 1'b0;
    bus.aluoutM    = '0;
    bus.writedataM = '0;
    bus.out_ready  = 1'b0;
    bus.clr_stats  = 1'b0;
    tick();
    tick();
    chk("rst_level", bus.level, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_drop", bus.drop_cnt, 0);
    chk("rst_addr", bus.out_addr, 0);
    reset = 1'b0;

    // Single store, one cycle of latency to the head.
    store(32'h40, 32'hDEADBEEF);
    chk("single_valid", bus.out_valid, 1);
    chk("single_addr", bus.out_addr, 32'h40);
    chk("single_data", bus.out_data, 32'hDEADBEEF);
    chk("single_seq", bus.out_seq, 0);
    chk("single_level", bus.level, 1);
    chk("single_misal", bus.out_misaligned, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Ten stores into an eight-entry FIFO with no consumer.
    for (int i = 0; i < 10; i++) begin
      store(32'h80 + 32'(4 * i), 32'(i));
      chk("fill_head_seq", bus.out_seq, 0);
    end
    chk("fill_level", bus.level, 8);
    chk("fill_ovf", bus.overflow, 1);
    chk("fill_drop", bus.drop_cnt, 2);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", bus.out_seq, 64'(i));
      chk("drain_data", bus.out_data, 64'(i));
      tick();
    end
    chk("drain_level", bus.level, 0);
    chk("drain_valid", bus.out_valid, 0);
    chk("drain_data0", bus.out_data, 0);
    bus.out_ready = 1'b0;

    // The two dropped stores leave a gap of two sequence numbers.
    store(32'h50, 32'h1234);
    chk("gap_seq", bus.out_seq, 10);
    for (int i = 0; i < 7; i++) store(32'h60, 32'h100 + 32'(i));
    chk("full_level", bus.level, 8);

    // Push while full is accepted because the head leaves in the same cycle.
    bus.out_ready = 1'b1;
    store(32'h70, 32'hCAFE);
    chk("fullpop_level", bus.level, 8);
    chk("fullpop_drop", bus.drop_cnt, 2);
    for (int i = 0; i < 8; i++) begin
      chk("fullpop_seq", bus.out_seq, 64'(11 + i));
      if (i == 7) chk("fullpop_last", bus.out_data, 32'hCAFE);
      tick();
    end
    chk("fullpop_empty", bus.level, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_ovf", bus.overflow, 0);

    // Streaming with the consumer always ready exercises pointer wrap.
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      store(32'(4 * k), 32'h2000 + 32'(k));
      chk("wrap_seq", bus.out_seq, 64'(k));
      chk("wrap_level", bus.level, 1);
    end
    tick();
    chk("wrap_end_level", bus.level, 0);
    chk("wrap_ovf", bus.overflow, 0);
    bus.out_ready = 1'b0;

    // Misaligned store, then fill and overflow with a clear.
    store(32'h43, 32'h55);
    chk("misal_flag", bus.out_misaligned, 1);
    chk("misal_addr", bus.out_addr, 32'h43);
    for (int i = 0; i < 8; i++) store(32'h44, 32'(i));
    chk("misal_drop", bus.drop_cnt, 1);
    bus.clr_stats = 1'b1;
    store(32'h48, 32'h99);
    chk("clr_drop_ovf", bus.overflow, 1);
    chk("clr_drop_cnt", bus.drop_cnt, 1);
    tick();
    bus.clr_stats = 1'b0;
    chk("clr_ovf", bus.overflow, 0);
    chk("clr_cnt", bus.drop_cnt, 0);

    // Reset in the middle of a drain at level 5.
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_level", bus.level, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_level0", bus.level, 0);
    store(32'h20, 32'h77);
    chk("mid_seq", bus.out_seq, 0);

`ifdef STORE_TRACE_FILTER_EN
    // Out-of-window store is ignored while the head is popped.
    bus.out_ready = 1'b1;
    store(32'h200, 32'h88);
    chk("filt_level", bus.level, 0);
    bus.out_ready = 1'b0;
    store(32'h24, 32'h89);
    chk("filt_seq", bus.out_seq, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
